// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues word-aligned requests to
//               instruction memory, tracks requests in an in-order slot ring
//               and presents one {pc, instr} pair per cycle to IF/ID.
//               Handles decode stall and redirects, and drops stale responses.
// Optional    : FETCH_JAL_PREDICT_EN - when defined, a captured JAL steers
//               fetch to its target and squashes younger requests.
// Ports       : clk, rst_n                  clock, async active-low reset
//               imem_req_valid/ready/addr    fetch request channel
//               imem_rsp_valid/data          in-order fetch responses
//               redirect_valid/pc            flush and restart fetch
//               id_stall                     decode back-pressure
//               if_id_valid/instr/pc         head instruction to decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc
);

    localparam int          IW    = $clog2(DEPTH);
    localparam int          PW    = IW + 1;
    // Discard counter must absorb several back-to-back flushes.
    localparam int          DW    = 16;
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      slot_pc_q    [DEPTH];
    logic [31:0]      slot_instr_q [DEPTH];
    logic [DEPTH-1:0] slot_filled_q;
    logic [PW-1:0]    alloc_q, alloc_d;
    logic [PW-1:0]    fill_q,  fill_d;
    logic [PW-1:0]    head_q,  head_d;
    logic [PW-1:0]    count_q, count_d;
    logic [DW-1:0]    discard_q, discard_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic          w_req_fire;
    logic          w_rsp_take;
    logic          w_consume;
    logic [PW-1:0] w_unfilled;
    logic [IW-1:0] w_alloc_idx, w_fill_idx, w_head_idx;
    logic          w_unused;

    assign w_alloc_idx = alloc_q[IW-1:0];
    assign w_fill_idx  = fill_q[IW-1:0];
    assign w_head_idx  = head_q[IW-1:0];

    // Gated by rst_n so no request leaks out while reset is held.
    assign imem_req_valid = rst_n && (count_q < PW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses belong to the oldest unfilled slot unless still owed to a flush.
    assign w_rsp_take = imem_rsp_valid && (discard_q == '0);

    assign if_id_valid = slot_filled_q[w_head_idx];
    assign if_id_instr = if_id_valid ? slot_instr_q[w_head_idx] : C_NOP;
    assign if_id_pc    = if_id_valid ? slot_pc_q[w_head_idx]    : 32'h0;
    assign w_consume   = if_id_valid && !id_stall;

    // Requests issued but not yet answered.
    assign w_unfilled = alloc_q - fill_q;

    // Low address bits of a redirect target are forced to zero.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

`ifdef FETCH_JAL_PREDICT_EN
    logic          w_is_jal;
    logic [31:0]   w_jal_imm;
    logic [31:0]   w_jal_target;
    logic [PW-1:0] w_fill_next;
    logic [PW-1:0] w_younger;

    assign w_is_jal     = (imem_rsp_data[6:0] == 7'b1101111);
    assign w_jal_imm    = {{11{imem_rsp_data[31]}}, imem_rsp_data[31],
                           imem_rsp_data[19:12], imem_rsp_data[20],
                           imem_rsp_data[30:21], 1'b0};
    assign w_jal_target = slot_pc_q[w_fill_idx] + w_jal_imm;
    assign w_fill_next  = fill_q + 1'b1;
    // Outstanding requests behind the JAL slot; they become stale.
    assign w_younger    = alloc_q - w_fill_next;
`endif

    always_comb begin
        pc_d      = pc_q;
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        head_d    = head_q;
        count_d   = count_q + PW'(w_req_fire) - PW'(w_consume);
        discard_d = discard_q;

        if (w_req_fire) begin
            pc_d    = pc_q + 32'd4;
            alloc_d = alloc_q + 1'b1;
        end

        if (imem_rsp_valid) begin
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (w_consume) begin
            head_d = head_q + 1'b1;
        end

`ifdef FETCH_JAL_PREDICT_EN
        // Truncate the ring right after the JAL; a request handshaking in
        // this same cycle is younger too and must also be discarded.
        if (w_rsp_take && w_is_jal) begin
            pc_d      = w_jal_target;
            alloc_d   = w_fill_next;
            count_d   = w_fill_next - head_q - PW'(w_consume);
            discard_d = discard_q + DW'(w_younger) + DW'(w_req_fire);
        end
`endif

        // A redirect overrides everything; a response arriving now is stale.
        if (redirect_valid) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            alloc_d   = '0;
            fill_d    = '0;
            head_d    = '0;
            count_d   = '0;
            discard_d = discard_q + DW'(w_unfilled) - DW'(imem_rsp_valid);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            alloc_q       <= '0;
            fill_q        <= '0;
            head_q        <= '0;
            count_q       <= '0;
            discard_q     <= '0;
            slot_filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]    <= 32'h0;
                slot_instr_q[i] <= 32'h0;
            end
        end else begin
            pc_q      <= pc_d;
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            head_q    <= head_d;
            count_q   <= count_d;
            discard_q <= discard_d;

            if (redirect_valid) begin
                slot_filled_q <= '0;
            end else begin
                // Alloc, fill and head slots are always distinct when active.
                if (w_req_fire) begin
                    slot_pc_q[w_alloc_idx]     <= pc_q;
                    slot_filled_q[w_alloc_idx] <= 1'b0;
                end
                if (w_rsp_take) begin
                    slot_instr_q[w_fill_idx]  <= imem_rsp_data;
                    slot_filled_q[w_fill_idx] <= 1'b1;
                end
                if (w_consume) begin
                    slot_filled_q[w_head_idx] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage ahead of decode and immediate generation. Issues word-aligned fetch requests to instruction memory over a valid/ready channel and tracks up to DEPTH in-flight or buffered instructions in an in-order slot ring. Presents one {pc, instruction} pair per cycle to the IF/ID boundary. Honours decode stall and execute-stage redirects, discarding stale responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 4: slot ring entries, covering outstanding plus buffered; power of two, ≥2.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; in order, exactly one per accepted request, latency ≥1 cycle.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] ignored, forced 0.
- id_stall  in  1  decode cannot accept this cycle.
- if_id_valid  out  1  head instruction valid.
- if_id_instr  out  32  head instruction.
- if_id_pc  out  32  address of head instruction.

## Operation
- State: pc_q (next fetch address), ring of DEPTH slots {pc, instr, filled}, alloc/fill/head pointers (log2(DEPTH)+1 bits, wrap modulo 2·DEPTH), occupancy count, discard counter.
- Request: imem_req_valid = (occupancy < DEPTH) && !redirect_valid; imem_req_addr = pc_q. On handshake: allocate slot at alloc pointer with pc = pc_q, filled = 0; pc_q += 4, wrapping modulo 2^32.
- Response: if discard > 0, drop data and decrement discard. Otherwise write instr into slot at fill pointer, set filled, advance fill pointer.
- Output: if_id_valid = head slot filled; if_id_instr/if_id_pc from head slot. Consume when if_id_valid && !id_stall: free head slot, advance head. When not valid, if_id_instr = 32'h0000_0013 (NOP) and if_id_pc = 0.
- Redirect, highest priority: clear all slots, occupancy 0, all pointers equal; pc_q = {redirect_pc[31:2],2'b00}; discard = discard + unfilled outstanding − (imem_rsp_valid ? 1 : 0). A response in the redirect cycle is always dropped. Same-cycle consume is ignored.
- Simultaneous request, response and consume update the occupancy counter with net effect; no event is lost.
- Full (occupancy = DEPTH): no request. Empty: if_id_valid = 0.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests are not expected; the memory is reset together with this block.

## Timing
- Reset values: imem_req_valid 0 while rst_n low, imem_req_addr RESET_PC, if_id_valid 0, if_id_instr 32'h0000_0013, if_id_pc 0.
- First request is asserted in the first cycle after rst_n deasserts.
- A response captured at edge N makes the instruction visible in cycle N+1, registered.
- imem_req_valid depends on registered occupancy and on redirect_valid only. There is no same-cycle credit from a consume.
- Sustained 1 instruction/cycle with 1-cycle memory requires DEPTH ≥ 3.
- Redirect in cycle N: the first request to the new pc is issued in cycle N+1.

## Configuration
- FETCH_JAL_PREDICT_EN defined: on capturing a non-discarded response with instr[6:0] = 7'b1101111, set pc_q = slot pc + sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Free all younger slots and add the younger unfilled outstanding count to discard.
  - The JAL itself is still delivered.
  - External redirect in the same cycle takes priority.
- Undefined: no instruction inspection. Fetch stays sequential until redirect_valid.

## Test plan
- Reset release, memory ready, 1-cycle latency, DEPTH=4, no stall: addresses 0,4,8,… one per cycle; if_id_pc increments by 4 each cycle from the third cycle.
- id_stall held 10 cycles: occupancy saturates at 4, imem_req_valid drops, if_id_instr stable; on release, in-order drain with no loss or duplication.
- redirect_pc = 32'h0000_0103 with 3 outstanding requests at 5-cycle latency: 3 responses dropped; next request address 32'h0000_0100; first delivered pc 0x100.
- Redirect coincident with a response and with a consume: response dropped, if_id_valid 0 the next cycle, discard correct.
- imem_req_ready randomly low 50 %: address sequence contiguous, delivered order matches request order.
- FETCH_JAL_PREDICT_EN, JAL offset +0x40 at pc 0x10: delivered pcs 0x10 then 0x50; instructions at 0x14/0x18 never delivered.
